cim_wb_initiator: RTL and testbench

// - Wishbone classic single-transfer master (initiator) that drives the Neuromorphic_X1_wb CIM macro slave port.
// - Accepts read/write commands from an on-chip sequencer or LA bridge through a small command FIFO.
// - Runs one bus cycle at a time and returns a response (read data or timeout error) via a valid/ready port.
// - Sits between the control logic and the macro's wbs_* pins inside the user project.

---
 rtl/cim_wb_pkg.sv | 21 ++
 rtl/cim_cmd_fifo.sv | 47 ++++
 rtl/cim_wb_initiator.sv | 125 ++++++++++++
 tb/tb_cim_wb_initiator.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_wb_pkg.sv
// Shared types and constants for the CIM Wishbone initiator.
package cim_wb_pkg;

  // Initiator FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Command word packing: {we, adr, dat, sel}
  localparam int CMD_W       = 69;
  localparam int CMD_SEL_LSB = 0;
  localparam int CMD_DAT_LSB = 4;
  localparam int CMD_ADR_LSB = 36;
  localparam int CMD_WE_BIT  = 68;

  // Data returned with writes and timed-out transfers
  localparam logic [31:0] RSP_ERR_DAT = 32'h0;

endpackage

// File: rtl/cim_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one wrap bit so full and
// empty are distinguished without a separate occupancy counter.
module cim_cmd_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointer advance on accepted push/pop; flushed by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array write; contents need no reset
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cim_wb_initiator.sv
// Wishbone classic single-transfer initiator for the Neuromorphic_X1_wb
// macro. Commands are queued in a small FIFO and executed one bus cycle
// at a time; each cycle yields one response (read data or timeout).
module cim_wb_initiator
  import cim_wb_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CMD_W-1:0] fifo_dout;

  // Head is consumed only on the IDLE->BUS transition
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  cim_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .din   ({cmd_we, cmd_adr, cmd_dat, cmd_sel}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Transfer FSM: bus launch, ack/timeout resolution, response hold
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            wbm_we_o  <= fifo_dout[CMD_WE_BIT];
            wbm_adr_o <= fifo_dout[CMD_ADR_LSB +: 32];
            wbm_dat_o <= fifo_dout[CMD_DAT_LSB +: 32];
            wbm_sel_o <= fifo_dout[CMD_SEL_LSB +: 4];
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            tmo_cnt   <= '0;
            state     <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ack takes priority over a timeout landing on the same edge
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= wbm_we_o ? RSP_ERR_DAT : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= RSP_ERR_DAT;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
            state     <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_wb_initiator.sv
// Directed bench for cim_wb_initiator: read, write with wait states,
// timeout, ack/timeout collision, FIFO backpressure and async reset.
module tb_cim_wb_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        busy;
  logic [7:0]  err_cnt;

  // Slave model: manual ack/data, or zero-wait auto ack returning adr ^ 0x5A5A0000
  logic        auto_ack;
  logic        ack_man;
  logic [31:0] dat_man;
  assign wbm_ack_i = auto_ack ? (wbm_cyc_o & wbm_stb_o) : ack_man;
  assign wbm_dat_i = auto_ack ? (wbm_adr_o ^ 32'h5A5A_0000) : dat_man;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cim_wb_initiator #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  task automatic push(input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel);
    @(negedge clk);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 1000000",
               {cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy});
    end
    checks++;
    if ({rsp_dat, wbm_adr_o, wbm_dat_o, wbm_sel_o, err_cnt} !== 108'h0) begin
      errors++;
      $display("FAIL reset_data: rsp_dat=%h adr=%h dat=%h sel=%h err_cnt=%0d expected all 0",
               rsp_dat, wbm_adr_o, wbm_dat_o, wbm_sel_o, err_cnt);
    end
  endtask

  task automatic test_read;
    push(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    @(negedge clk);
    checks++;
    if (wbm_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL read_latency: cyc=%b expected 0 one cycle after push", wbm_cyc_o);
    end
    @(negedge clk);
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o} !== {3'b110, 32'h3000_0004}) begin
      errors++;
      $display("FAIL read_bus: cyc/stb/we=%b%b%b adr=%h expected 110 30000004",
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o);
    end
    ack_man = 1'b1;
    dat_man = 32'hA5A5_0001;
    @(negedge clk);
    ack_man = 1'b0;
    checks++;
    if ({wbm_stb_o, rsp_valid, rsp_err, rsp_dat} !== {3'b010, 32'hA5A5_0001}) begin
      errors++;
      $display("FAIL read_rsp: stb=%b valid=%b err=%b dat=%h expected 0 1 0 a5a50001",
               wbm_stb_o, rsp_valid, rsp_err, rsp_dat);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL read_release: valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_write_wait;
    push(1'b1, 32'h3000_0000, 32'h1234_5678, 4'hF);
    dat_man = 32'hDEAD_BEEF;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !==
          {3'b111, 4'hF, 32'h3000_0000, 32'h1234_5678}) begin
        errors++;
        $display("FAIL write_stable[%0d]: cyc/stb/we=%b%b%b sel=%h adr=%h dat=%h", i,
                 wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
      end
      if (i == 3) ack_man = 1'b1;
    end
    @(negedge clk);
    ack_man = 1'b0;
    checks++;
    if ({wbm_cyc_o, rsp_valid, rsp_err, rsp_dat} !== {3'b010, 32'h0}) begin
      errors++;
      $display("FAIL write_rsp: cyc=%b valid=%b err=%b dat=%h expected 0 1 0 00000000",
               wbm_cyc_o, rsp_valid, rsp_err, rsp_dat);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int n;
    int w;
    push(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    w = 0;
    while (!wbm_stb_o && w < 10) begin
      @(negedge clk);
      w++;
    end
    n = 0;
    while (wbm_stb_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL timeout_len: stb high %0d cycles expected 64", n);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat, err_cnt} !== {2'b11, 32'h0, 8'd1}) begin
      errors++;
      $display("FAIL timeout_rsp: valid=%b err=%b dat=%h err_cnt=%0d expected 1 1 0 1",
               rsp_valid, rsp_err, rsp_dat, err_cnt);
    end
    ack_man = 1'b1;
    dat_man = 32'h7777_7777;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL late_ack_resp: valid=%b err=%b dat=%h expected 1 1 0",
               rsp_valid, rsp_err, rsp_dat);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    ack_man = 1'b0;
    checks++;
    if ({wbm_cyc_o, rsp_valid, busy, err_cnt} !== {3'b000, 8'd1}) begin
      errors++;
      $display("FAIL late_ack_idle: cyc=%b valid=%b busy=%b err_cnt=%0d expected 0 0 0 1",
               wbm_cyc_o, rsp_valid, busy, err_cnt);
    end
  endtask

  task automatic test_ack_at_timeout;
    int w;
    push(1'b0, 32'h3000_0020, 32'h0, 4'h3);
    w = 0;
    while (!wbm_stb_o && w < 10) begin
      @(negedge clk);
      w++;
    end
    repeat (63) @(negedge clk);
    checks++;
    if (wbm_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL coincide_pre: stb=%b expected 1 after 63 ackless cycles", wbm_stb_o);
    end
    ack_man = 1'b1;
    dat_man = 32'hC0FF_EE64;
    @(negedge clk);
    ack_man = 1'b0;
    checks++;
    if ({wbm_stb_o, rsp_valid, rsp_err, rsp_dat, err_cnt} !== {3'b010, 32'hC0FF_EE64, 8'd1}) begin
      errors++;
      $display("FAIL coincide_rsp: stb=%b valid=%b err=%b dat=%h err_cnt=%0d expected 0 1 0 c0ffee64 1",
               wbm_stb_o, rsp_valid, rsp_err, rsp_dat, err_cnt);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_dat [5];
    int got;
    int cyc_n;
    exp_dat[0] = 32'h5A5A_0100;
    exp_dat[1] = 32'h5A5A_0104;
    exp_dat[2] = 32'h5A5A_0108;
    exp_dat[3] = 32'h5A5A_010C;
    exp_dat[4] = 32'h5A5A_0110;
    auto_ack = 1'b1;
    for (int i = 0; i < 5; i++)
      push(1'b0, 32'h0000_0100 + 32'(4 * i), 32'h0, 4'hF);
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL bp_full: cmd_ready=%b busy=%b expected 0 1", cmd_ready, busy);
    end
    cmd_we = 1'b0; cmd_adr = 32'h0000_0200; cmd_sel = 4'hF; cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_dat} !== {2'b01, exp_dat[0]}) begin
      errors++;
      $display("FAIL bp_stall: cmd_ready=%b valid=%b dat=%h expected 0 1 %h",
               cmd_ready, rsp_valid, rsp_dat, exp_dat[0]);
    end
    rsp_ready = 1'b1;
    got = 0;
    cyc_n = 0;
    while (got < 5 && cyc_n < 100) begin
      if (rsp_valid) begin
        checks++;
        if ({rsp_err, rsp_dat} !== {1'b0, exp_dat[got]}) begin
          errors++;
          $display("FAIL bp_order[%0d]: err=%b dat=%h expected 0 %h",
                   got, rsp_err, rsp_dat, exp_dat[got]);
        end
        got++;
      end
      @(negedge clk);
      cyc_n++;
    end
    rsp_ready = 1'b0;
    auto_ack  = 1'b0;
    checks++;
    if (got != 5 || {busy, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_drain: responses=%0d busy=%b cmd_ready=%b expected 5 0 1",
               got, busy, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_bus;
    int w;
    push(1'b1, 32'h3000_0040, 32'h0000_00AA, 4'h1);
    push(1'b1, 32'h3000_0044, 32'h0000_00BB, 4'h2);
    w = 0;
    while (!wbm_stb_o && w < 10) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o} !== 2'b00) begin
      errors++;
      $display("FAIL rst_async: cyc=%b stb=%b expected 0 0 before next edge", wbm_cyc_o, wbm_stb_o);
    end
    checks++;
    if ({cmd_ready, busy, rsp_valid, err_cnt} !== {3'b100, 8'd0}) begin
      errors++;
      $display("FAIL rst_state: cmd_ready=%b busy=%b valid=%b err_cnt=%0d expected 1 0 0 0",
               cmd_ready, busy, rsp_valid, err_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({wbm_cyc_o, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_no_replay: cyc=%b busy=%b expected 0 0", wbm_cyc_o, busy);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    auto_ack  = 1'b0;
    ack_man   = 1'b0;
    dat_man   = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_read;
    test_write_wait;
    test_timeout;
    test_ack_at_timeout;
    test_backpressure;
    test_reset_mid_bus;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
